jacobian_to_affine: RTL
=======================

Name: jacobian_to_affine

Overview:
Converts a secp256k1 point from Jacobian (X, Y, Z) to affine (x, y), with x = X/Z^2 and y = Y/Z^3 mod P. It sits at the output end of the point_add / scalar-multiply datapath and produces the coordinates that leave the ECC core. Z^-1 is computed by Fermat inversion (Z^(P-2)) using one internal mod_mul instance, time-shared, with the same start/done handshake style as the adders.

Parameters:
WIDTH, 256, coordinate and field width in bits.
P, 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F, field prime; the inversion exponent is the constant P-2.

Ports:
clk  in  1  system clock, all logic on posedge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request; sampled only in IDLE.
X  in  WIDTH  Jacobian X, reduced (<P).
Y  in  WIDTH  Jacobian Y, reduced (<P).
Z  in  WIDTH  Jacobian Z, reduced (<P).
x  out  WIDTH  affine x, valid from done onward.
y  out  WIDTH  affine y, valid from done onward.
inf  out  1  result is the point at infinity (Z==0); valid with done.
busy  out  1  high from the cycle after an accepted start until done.
done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n low): state=IDLE; x=0, y=0, inf=0, busy=0, done=0. The mod_mul instance is reset with ~rst_n. Reset mid-operation aborts; no done is issued.
- IDLE: start=1 latches X, Y, Z, sets busy, and clears inf. If Z==0, go to FINISH with x=0, y=0, inf=1 and no mod_mul operations. Otherwise acc=Z, bit index i=254, go to INV_SQR.
- INV_SQR: issue acc*acc. On mul done, acc=result. If bit i of P-2 is 1, go to INV_MUL; otherwise decrement i, or go to ZSQ if i==0.
- INV_MUL: issue acc*Z. On mul done, acc=result, then decrement i, or go to ZSQ if i==0.
- Inversion totals are fixed: 255 squarings and 248 multiplies, for 503 mod_mul ops.
- ZSQ: zi2=zinv*zinv. ZCUBE: zi3=zi2*zinv. XMUL: x=X*zi2. YMUL: y=Y*zi3, then go to FINISH.
- Total mod_mul ops for Z!=0: exactly 507.
- FINISH: done=1 for one cycle, busy=0, return to IDLE. x, y and inf hold until the next accepted start.
- Multiplier handshake:
  - start_mul is asserted for exactly one cycle per op, with operands stable from that cycle until mul done.
  - Each state waits for mul done and ignores it in the issue cycle.
  - A new op is issued on the cycle after the done is consumed.
- start while busy is ignored: no re-latch and no effect on the running op.
- start in the same cycle as done (FINISH) is ignored; it is accepted only in IDLE, one cycle later.
- Out of contract: inputs >=P. No reduction is performed on the inputs.
- The exponent bits come from a constant; no 256-bit exponent register is shifted.
- i is an 8-bit down-counter.

Decomposition:
- Shared package ecc_pkg: WIDTH, P, P_MINUS_2 constant, and a state enum (IDLE, INV_SQR, INV_MUL, ZSQ, ZCUBE, XMUL, YMUL, FINISH).
- One sub-module: the existing mod_mul, instantiated once.
- Inversion stays inline, not a separate mod_inv; it can be split out later if point_add needs it.

Test Plan:
- X=5, Y=7, Z=1 -> x=5, y=7, inf=0. done after exactly 507 mod_mul starts (bench counts start_mul).
- Z=P-1 (i.e. -1), X=0x1234, Y=0x5678 -> x=0x1234, y=P-0x5678, inf=0.
- G with Z=2: X=4*Gx mod P, Y=8*Gy mod P -> x=79BE667E...16F81798, y=483ADA77...FB10D4B8.
- Z=0, any X/Y -> done within 3 cycles of start, inf=1, x=y=0, zero mod_mul starts.
- Second start pulses at op 100 of a conversion -> result equals the first request's answer, and exactly one done is issued.
- Assert rst_n low at op 300, release, then issue start with Z=1, X=9, Y=3 -> outputs 0 during reset, then x=9, y=3, and a single done.

Source files
------------

// File: rtl/ecc_pkg.sv
//------------------------------------------------------------------------------
// Module : ecc_pkg
// Brief  : secp256k1 field constants and the coordinate-conversion state set.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package ecc_pkg;

    localparam int             WIDTH     = 256;
    localparam logic [255:0]   P         = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0]   P_MINUS_2 = P - 256'd2;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INV_SQR = 3'd1,
        INV_MUL = 3'd2,
        ZSQ     = 3'd3,
        ZCUBE   = 3'd4,
        XMUL    = 3'd5,
        YMUL    = 3'd6,
        FINISH  = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_mul.sv
//------------------------------------------------------------------------------
// Module : mod_mul
// Brief  : Modular multiply mod the secp256k1 prime, start/done handshake,
//          result three cycles after start.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mod_mul
    import ecc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_done
);

    localparam int          c_pw   = 2 * WIDTH;
    localparam int          c_t1w  = WIDTH + 34;
    localparam int          c_t2w  = WIDTH + 1;
    // 2^256 mod P = 2^32 + 977, so the high half folds back with one small multiply
    localparam logic [32:0] c_fold = 33'h1_0000_03D1;

    logic [c_pw-1:0]  r_prod;
    logic [c_t1w-1:0] r_t1;
    logic [WIDTH-1:0] r_res;
    logic             r_v1;
    logic             r_v2;
    logic             r_done;

    logic [c_t1w-1:0] w_t1;
    logic [c_t2w-1:0] w_t2;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_red;

    assign w_t1  = c_t1w'(r_prod[c_pw-1:WIDTH]) * c_t1w'(c_fold) + c_t1w'(r_prod[WIDTH-1:0]);
    // Second fold leaves a value below 2P, so a single conditional subtract finishes it
    assign w_t2  = c_t2w'(r_t1[c_t1w-1:WIDTH]) * c_t2w'(c_fold) + c_t2w'(r_t1[WIDTH-1:0]);
    assign w_sub = w_t2[WIDTH-1:0] - P;
    assign w_red = (w_t2 >= c_t2w'(P)) ? w_sub : w_t2[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_v1   <= i_start;
            r_v2   <= r_v1;
            r_done <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (i_start) r_prod <= c_pw'(i_a) * c_pw'(i_b);
        if (r_v1)    r_t1   <= w_t1;
        if (r_v2)    r_res  <= w_red;
    end

    assign o_result = r_res;
    assign o_done   = r_done;

endmodule

`default_nettype wire

// File: rtl/jacobian_to_affine.sv
//------------------------------------------------------------------------------
// Module : jacobian_to_affine
// Brief  : Jacobian (X,Y,Z) to affine (x,y) via Fermat inversion on one mod_mul.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module jacobian_to_affine
    import ecc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    input  logic [WIDTH-1:0] Z,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             inf,
    output logic             busy,
    output logic             done
);

    state_t           r_state;
    logic [WIDTH-1:0] r_x_in;
    logic [WIDTH-1:0] r_y_in;
    logic [WIDTH-1:0] r_z;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_zi2;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [7:0]       r_i;
    logic             r_inf;
    logic             r_issued;
    logic             r_start_mul;

    logic [WIDTH-1:0] w_op_a;
    logic [WIDTH-1:0] w_op_b;
    logic [WIDTH-1:0] w_mul_result;
    logic             w_mul_done;
    logic             w_last;

    mod_mul u_mod_mul (
        .clk      (clk),
        .rst      (~rst_n),
        .i_start  (r_start_mul),
        .i_a      (r_op_a),
        .i_b      (r_op_b),
        .o_result (w_mul_result),
        .o_done   (w_mul_done)
    );

    // r_acc holds the running power during inversion, then Z^-1, then Z^-3
    always_comb begin
        w_op_a = r_acc;
        w_op_b = r_acc;
        case (r_state)
            INV_MUL: w_op_b = r_z;
            ZCUBE:   w_op_a = r_zi2;
            XMUL: begin
                w_op_a = r_x_in;
                w_op_b = r_zi2;
            end
            YMUL:    w_op_a = r_y_in;
            default: ;
        endcase
    end

    assign w_last = (r_i == 8'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_x_in      <= '0;
            r_y_in      <= '0;
            r_z         <= '0;
            r_acc       <= '0;
            r_zi2       <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_i         <= 8'd0;
            r_inf       <= 1'b0;
            r_issued    <= 1'b0;
            r_start_mul <= 1'b0;
        end else begin
            r_start_mul <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_x_in   <= X;
                        r_y_in   <= Y;
                        r_z      <= Z;
                        r_inf    <= 1'b0;
                        r_issued <= 1'b0;
                        if (Z == '0) begin
                            r_x     <= '0;
                            r_y     <= '0;
                            r_inf   <= 1'b1;
                            r_state <= FINISH;
                        end else begin
                            r_acc   <= Z;
                            r_i     <= 8'd254;
                            r_state <= INV_SQR;
                        end
                    end
                end
                FINISH: r_state <= IDLE;
                default: begin
                    if (!r_issued) begin
                        r_start_mul <= 1'b1;
                        r_op_a      <= w_op_a;
                        r_op_b      <= w_op_b;
                        r_issued    <= 1'b1;
                    end else if (w_mul_done && !r_start_mul) begin
                        r_issued <= 1'b0;
                        case (r_state)
                            INV_SQR: begin
                                r_acc <= w_mul_result;
                                if (P_MINUS_2[r_i]) r_state <= INV_MUL;
                                else if (w_last)    r_state <= ZSQ;
                                else                r_i     <= r_i - 8'd1;
                            end
                            INV_MUL: begin
                                r_acc <= w_mul_result;
                                if (w_last) begin
                                    r_state <= ZSQ;
                                end else begin
                                    r_i     <= r_i - 8'd1;
                                    r_state <= INV_SQR;
                                end
                            end
                            ZSQ: begin
                                r_zi2   <= w_mul_result;
                                r_state <= ZCUBE;
                            end
                            ZCUBE: begin
                                r_acc   <= w_mul_result;
                                r_state <= XMUL;
                            end
                            XMUL: begin
                                r_x     <= w_mul_result;
                                r_state <= YMUL;
                            end
                            YMUL: begin
                                r_y     <= w_mul_result;
                                r_state <= FINISH;
                            end
                            default: r_state <= IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign x    = r_x;
    assign y    = r_y;
    assign inf  = r_inf;
    assign done = (r_state == FINISH);
    assign busy = (r_state != IDLE) && (r_state != FINISH);

endmodule

`default_nettype wire
